// File: rtl/rtc_pkg.sv
// Shared constants and helpers for the BCD real-time clock.
package rtc_pkg;

  localparam logic [7:0] SEC_MAX   = 8'h59;
  localparam logic [7:0] HR12_MAX  = 8'h12;
  localparam logic [7:0] HR24_MAX  = 8'h23;
  localparam logic [7:0] HR12_RST  = 8'h12;
  localparam logic [7:0] HR24_RST  = 8'h00;
  localparam logic [7:0] HR12_WRAP = 8'h01;
  localparam logic [7:0] HR24_WRAP = 8'h00;

  // Both nibbles are decimal digits and the packed value does not exceed max.
  function automatic logic bcd_valid(input logic [7:0] b, input logic [7:0] max);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b <= max);
  endfunction

endpackage

// File: rtl/bcd_rtc_if.sv
// Time/alarm bus between the RTC and its controller/display logic.
interface bcd_rtc_if;
  logic       ena;
  logic       load;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic       load_pm;
  logic       alarm_wr;
  logic [7:0] alarm_hh;
  logic [7:0] alarm_mm;
  logic       alarm_pm;
  logic       alarm_en;
  logic       alarm_ack;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       pm;
  logic       sec_tick;
  logic       load_err;
  logic       alarm;

  modport master (
    output ena, load, load_hh, load_mm, load_ss, load_pm,
           alarm_wr, alarm_hh, alarm_mm, alarm_pm, alarm_en, alarm_ack,
    input  hh, mm, ss, pm, sec_tick, load_err, alarm
  );

  modport slave (
    input  ena, load, load_hh, load_mm, load_ss, load_pm,
           alarm_wr, alarm_hh, alarm_mm, alarm_pm, alarm_en, alarm_ack,
    output hh, mm, ss, pm, sec_tick, load_err, alarm
  );
endinterface

// File: rtl/bcd2_counter.sv
// Two-digit packed-BCD counter with load, runtime limit and wrap value.
module bcd2_counter #(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] max,
  input  logic [7:0] wrap_val,
  output logic [7:0] q,
  output logic [7:0] nxt,
  output logic       carry
);

  logic [7:0] val_q, val_d;

  // Next value: load wins over increment; increment wraps at max.
  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = load_val;
    end else if (inc) begin
      if (val_q == max) begin
        val_d = wrap_val;
      end else if (val_q[3:0] == 4'd9) begin
        val_d = {val_q[7:4] + 4'd1, 4'd0};
      end else begin
        val_d = val_q + 8'd1;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) val_q <= RST_VAL;
    else       val_q <= val_d;
  end

  assign q     = val_q;
  assign nxt   = val_d;
  assign carry = inc && !load && (val_q == max);

endmodule

// File: rtl/bcd_rtc.sv
// BCD real-time clock: prescaler, validated load, 12/24-hour hours, sticky alarm.
module bcd_rtc
  import rtc_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter bit          MODE24   = 1'b0
) (
  input logic      clk,
  input logic      reset,
  bcd_rtc_if.slave bus
);

  localparam logic [7:0]  HR_MAX     = MODE24 ? HR24_MAX  : HR12_MAX;
  localparam logic [7:0]  HR_RST     = MODE24 ? HR24_RST  : HR12_RST;
  localparam logic [7:0]  HR_WRAP    = MODE24 ? HR24_WRAP : HR12_WRAP;
  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic        pm_q, pm_d;
  logic        sec_tick_q, load_err_q;
  logic        alarm_q, alarm_d;
  logic [7:0]  al_hh_q, al_mm_q;
  logic        al_pm_q;

  logic        adv, load_ok, step, match;
  logic        hh_valid;
  logic        c_ss, c_mm, c_hh;
  logic [7:0]  hh_q, mm_q, ss_q;
  logic [7:0]  hh_nx, mm_nx, ss_nx;

  // Load validation and advance qualification; an accepted load suppresses the advance.
  always_comb begin
    hh_valid = bcd_valid(bus.load_hh, HR_MAX) && (MODE24 || (bus.load_hh != 8'h00));
    load_ok  = bus.load && hh_valid
               && bcd_valid(bus.load_mm, SEC_MAX) && bcd_valid(bus.load_ss, SEC_MAX);
    adv      = bus.ena && (presc_q == PRESC_LAST);
    step     = adv && !load_ok;
  end

  bcd2_counter #(.RST_VAL(8'h00)) u_ss (
    .clk(clk), .reset(reset), .inc(step), .load(load_ok), .load_val(bus.load_ss),
    .max(SEC_MAX), .wrap_val(8'h00), .q(ss_q), .nxt(ss_nx), .carry(c_ss)
  );

  bcd2_counter #(.RST_VAL(8'h00)) u_mm (
    .clk(clk), .reset(reset), .inc(c_ss), .load(load_ok), .load_val(bus.load_mm),
    .max(SEC_MAX), .wrap_val(8'h00), .q(mm_q), .nxt(mm_nx), .carry(c_mm)
  );

  bcd2_counter #(.RST_VAL(HR_RST)) u_hh (
    .clk(clk), .reset(reset), .inc(c_mm), .load(load_ok), .load_val(bus.load_hh),
    .max(HR_MAX), .wrap_val(HR_WRAP), .q(hh_q), .nxt(hh_nx), .carry(c_hh)
  );

  // Prescaler, pm and alarm next state. In 24-hour mode pm is tracked as a
  // register too: set on 11->12, cleared on the 23->00 wrap, so it stays registered.
  always_comb begin
    presc_d = presc_q;
    if (load_ok)      presc_d = '0;
    else if (bus.ena) presc_d = adv ? '0 : presc_q + 16'd1;

    pm_d = pm_q;
    if (load_ok)                          pm_d = MODE24 ? (bus.load_hh >= 8'h12) : bus.load_pm;
    else if (c_mm && (hh_q == 8'h11))     pm_d = MODE24 ? 1'b1 : ~pm_q;
    else if (c_hh && MODE24)              pm_d = 1'b0;

    match = step && bus.alarm_en && (ss_nx == 8'h00)
            && (mm_nx == al_mm_q) && (hh_nx == al_hh_q)
            && (MODE24 || (pm_d == al_pm_q));

    alarm_d = alarm_q;
    if (match)              alarm_d = 1'b1;
    else if (bus.alarm_ack) alarm_d = 1'b0;
  end

  // Control and alarm registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      pm_q       <= 1'b0;
      sec_tick_q <= 1'b0;
      load_err_q <= 1'b0;
      alarm_q    <= 1'b0;
      al_hh_q    <= HR_RST;
      al_mm_q    <= 8'h00;
      al_pm_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      pm_q       <= pm_d;
      sec_tick_q <= step;
      load_err_q <= bus.load && !load_ok;
      alarm_q    <= alarm_d;
      if (bus.alarm_wr) begin
        al_hh_q <= bus.alarm_hh;
        al_mm_q <= bus.alarm_mm;
        al_pm_q <= bus.alarm_pm;
      end
    end
  end

  assign bus.hh       = hh_q;
  assign bus.mm       = mm_q;
  assign bus.ss       = ss_q;
  assign bus.pm       = pm_q;
  assign bus.sec_tick = sec_tick_q;
  assign bus.load_err = load_err_q;
  assign bus.alarm    = alarm_q;

endmodule

// File: tb/tb_bcd_rtc.sv
// Directed bench for bcd_rtc: 12-hour, 24-hour and prescaled instances.
module tb_bcd_rtc;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ticks = 0;

  always #5 clk = ~clk;

  bcd_rtc_if a ();
  bcd_rtc_if b ();
  bcd_rtc_if c ();

  bcd_rtc #(.TICK_DIV(1), .MODE24(1'b0)) u12 (.clk(clk), .reset(reset), .bus(a));
  bcd_rtc #(.TICK_DIV(1), .MODE24(1'b1)) u24 (.clk(clk), .reset(reset), .bus(b));
  bcd_rtc #(.TICK_DIV(4), .MODE24(1'b0)) u4  (.clk(clk), .reset(reset), .bus(c));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    a.ena = 0; a.load = 0; a.load_hh = 0; a.load_mm = 0; a.load_ss = 0; a.load_pm = 0;
    a.alarm_wr = 0; a.alarm_hh = 0; a.alarm_mm = 0; a.alarm_pm = 0; a.alarm_en = 0; a.alarm_ack = 0;
    b.ena = 0; b.load = 0; b.load_hh = 0; b.load_mm = 0; b.load_ss = 0; b.load_pm = 0;
    b.alarm_wr = 0; b.alarm_hh = 0; b.alarm_mm = 0; b.alarm_pm = 0; b.alarm_en = 0; b.alarm_ack = 0;
    c.ena = 0; c.load = 0; c.load_hh = 0; c.load_mm = 0; c.load_ss = 0; c.load_pm = 0;
    c.alarm_wr = 0; c.alarm_hh = 0; c.alarm_mm = 0; c.alarm_pm = 0; c.alarm_en = 0; c.alarm_ack = 0;
  endtask

  task automatic ld_a(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
    a.load = 1; a.load_hh = h; a.load_mm = m; a.load_ss = s; a.load_pm = p;
  endtask

  task automatic ld_b(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    b.load = 1; b.load_hh = h; b.load_mm = m; b.load_ss = s; b.load_pm = 0;
  endtask

  initial begin
    clr();
    reset = 1;
    step(2);
    chk("rst12_hh", a.hh, 8'h12);
    chk("rst12_mm", a.mm, 8'h00);
    chk("rst12_ss", a.ss, 8'h00);
    chk("rst12_pm", 8'(a.pm), 8'd0);
    chk("rst12_tick", 8'(a.sec_tick), 8'd0);
    chk("rst12_err", 8'(a.load_err), 8'd0);
    chk("rst12_alarm", 8'(a.alarm), 8'd0);
    chk("rst24_hh", b.hh, 8'h00);
    chk("rst24_pm", 8'(b.pm), 8'd0);
    reset = 0;

    // 12-hour free run
    a.ena = 1;
    step(1);
    chk("run_ss1", a.ss, 8'h01);
    chk("run_tick1", 8'(a.sec_tick), 8'd1);
    step(3599);
    chk("run1h_hh", a.hh, 8'h01);
    chk("run1h_mm", a.mm, 8'h00);
    chk("run1h_ss", a.ss, 8'h00);
    chk("run1h_pm", 8'(a.pm), 8'd0);
    step(3600);
    chk("run2h_hh", a.hh, 8'h02);
    chk("run2h_mm", a.mm, 8'h00);
    a.ena = 0;
    step(1);
    chk("hold_tick", 8'(a.sec_tick), 8'd0);
    chk("hold_ss", a.ss, 8'h00);

    // 11:59:59 AM -> 12:00:00 PM
    ld_a(8'h11, 8'h59, 8'h59, 1'b0);
    step(1);
    a.load = 0;
    chk("ld1_hh", a.hh, 8'h11);
    chk("ld1_ss", a.ss, 8'h59);
    chk("ld1_tick", 8'(a.sec_tick), 8'd0);
    chk("ld1_err", 8'(a.load_err), 8'd0);
    a.ena = 1;
    step(1);
    a.ena = 0;
    chk("noon_hh", a.hh, 8'h12);
    chk("noon_mm", a.mm, 8'h00);
    chk("noon_ss", a.ss, 8'h00);
    chk("noon_pm", 8'(a.pm), 8'd1);
    chk("noon_tick", 8'(a.sec_tick), 8'd1);

    // 12:59:59 PM -> 01:00:00 PM
    ld_a(8'h12, 8'h59, 8'h59, 1'b1);
    step(1);
    a.load = 0;
    a.ena = 1;
    step(1);
    chk("one_hh", a.hh, 8'h01);
    chk("one_mm", a.mm, 8'h00);
    chk("one_ss", a.ss, 8'h00);
    chk("one_pm", 8'(a.pm), 8'd1);

    // Rejected loads with concurrent advance
    ld_a(8'h13, 8'h00, 8'h00, 1'b0);
    step(1);
    chk("bad_hh_err", 8'(a.load_err), 8'd1);
    chk("bad_hh_hh", a.hh, 8'h01);
    chk("bad_hh_ss", a.ss, 8'h01);
    chk("bad_hh_tick", 8'(a.sec_tick), 8'd1);
    ld_a(8'h05, 8'h60, 8'h00, 1'b0);
    step(1);
    chk("bad_mm_err", 8'(a.load_err), 8'd1);
    chk("bad_mm_ss", a.ss, 8'h02);
    chk("bad_mm_mm", a.mm, 8'h00);
    ld_a(8'h05, 8'h00, 8'h0A, 1'b0);
    step(1);
    chk("bad_ss_err", 8'(a.load_err), 8'd1);
    chk("bad_ss_ss", a.ss, 8'h03);
    a.ena = 0;
    ld_a(8'h00, 8'h00, 8'h00, 1'b0);
    step(1);
    chk("bad_h0_err", 8'(a.load_err), 8'd1);
    chk("bad_h0_hh", a.hh, 8'h01);
    a.load = 0;
    step(1);
    chk("err_clear", 8'(a.load_err), 8'd0);
    chk("err_pm", 8'(a.pm), 8'd1);

    // Alarm 07:30 AM
    a.alarm_wr = 1; a.alarm_hh = 8'h07; a.alarm_mm = 8'h30; a.alarm_pm = 0; a.alarm_en = 1;
    step(1);
    a.alarm_wr = 0;
    ld_a(8'h07, 8'h30, 8'h00, 1'b0);
    step(1);
    a.load = 0;
    chk("al_load_nomatch", 8'(a.alarm), 8'd0);
    ld_a(8'h07, 8'h29, 8'h59, 1'b1);
    step(1);
    a.load = 0;
    a.ena = 1;
    step(1);
    a.ena = 0;
    chk("al_pm_nomatch", 8'(a.alarm), 8'd0);
    ld_a(8'h07, 8'h29, 8'h59, 1'b0);
    step(1);
    a.load = 0;
    a.ena = 1;
    step(1);
    a.ena = 0;
    chk("al_set", 8'(a.alarm), 8'd1);
    chk("al_tick", 8'(a.sec_tick), 8'd1);
    chk("al_mm", a.mm, 8'h30);
    step(1);
    chk("al_sticky", 8'(a.alarm), 8'd1);
    a.alarm_en = 0;
    step(1);
    chk("al_en0_keep", 8'(a.alarm), 8'd1);
    a.alarm_en = 1;
    ld_a(8'h07, 8'h29, 8'h59, 1'b0);
    step(1);
    a.load = 0;
    a.ena = 1; a.alarm_ack = 1;
    step(1);
    a.ena = 0;
    chk("al_ack_vs_set", 8'(a.alarm), 8'd1);
    step(1);
    a.alarm_ack = 0;
    chk("al_ack", 8'(a.alarm), 8'd0);

    // 24-hour mode
    ld_b(8'h23, 8'h59, 8'h59);
    step(1);
    b.load = 0;
    chk("h24_ld_pm", 8'(b.pm), 8'd1);
    b.ena = 1;
    step(1);
    b.ena = 0;
    chk("h24_wrap_hh", b.hh, 8'h00);
    chk("h24_wrap_mm", b.mm, 8'h00);
    chk("h24_wrap_ss", b.ss, 8'h00);
    chk("h24_wrap_pm", 8'(b.pm), 8'd0);
    chk("h24_wrap_tick", 8'(b.sec_tick), 8'd1);
    ld_b(8'h19, 8'h59, 8'h59);
    step(1);
    b.load = 0;
    b.ena = 1;
    step(1);
    b.ena = 0;
    chk("h24_20_hh", b.hh, 8'h20);
    chk("h24_20_pm", 8'(b.pm), 8'd1);
    ld_b(8'h11, 8'h59, 8'h59);
    step(1);
    b.load = 0;
    chk("h24_11_pm", 8'(b.pm), 8'd0);
    b.ena = 1;
    step(1);
    b.ena = 0;
    chk("h24_12_hh", b.hh, 8'h12);
    chk("h24_12_pm", 8'(b.pm), 8'd1);
    ld_b(8'h24, 8'h00, 8'h00);
    step(1);
    chk("h24_bad_err", 8'(b.load_err), 8'd1);
    chk("h24_bad_hh", b.hh, 8'h12);
    ld_b(8'h00, 8'h00, 8'h00);
    step(1);
    b.load = 0;
    chk("h24_zero_err", 8'(b.load_err), 8'd0);
    chk("h24_zero_hh", b.hh, 8'h00);

    // TICK_DIV=4 with ena toggling
    for (int k = 0; k < 16; k++) begin
      c.ena = (k % 2 == 0);
      step(1);
      ticks += int'(c.sec_tick);
      if (k == 5) chk("div_k5_ss", c.ss, 8'h00);
      if (k == 6) chk("div_k6_ss", c.ss, 8'h01);
    end
    chk("div_ss", c.ss, 8'h02);
    chk("div_ticks", 8'(ticks), 8'd2);
    c.ena = 1;
    step(2);
    c.load = 1; c.load_hh = 8'h12; c.load_mm = 8'h10; c.load_ss = 8'h00; c.load_pm = 0;
    step(1);
    c.load = 0;
    chk("div_ld_mm", c.mm, 8'h10);
    chk("div_ld_tick", 8'(c.sec_tick), 8'd0);
    step(3);
    chk("div_ld3_ss", c.ss, 8'h00);
    step(1);
    chk("div_ld4_ss", c.ss, 8'h01);
    chk("div_ld4_tick", 8'(c.sec_tick), 8'd1);
    c.ena = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_rtc.md
# bcd_rtc

Parametrised BCD real-time clock: successor to the team's fixed 12-hour hh:mm:ss counter. Adds a build-time 12/24-hour mode, an enable prescaler, a validated time-load port, and a sticky hh:mm alarm. It sits between the system tick/enable source and display/alarm logic; all outputs are packed BCD, two digits per byte.

## Interface

- `TICK_DIV`, default 1: number of cycles with `ena` high per one-second advance. Range 1..2^16.
- `MODE24`, default 0: 0 selects 12-hour mode (hours 01..12, with `pm`); 1 selects 24-hour mode (hours 00..23).
- `clk` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `ena` in 1: count enable, feeds the prescaler.
- `load` in 1: one-cycle request to load time.
- `load_hh`, `load_mm`, `load_ss` in 8 each: BCD time to load.
- `load_pm` in 1: PM flag to load; ignored when `MODE24`=1.
- `alarm_wr` in 1: write the alarm registers.
- `alarm_hh`, `alarm_mm` in 8 each: BCD alarm time.
- `alarm_pm` in 1: alarm PM flag.
- `alarm_en` in 1: alarm arming level.
- `alarm_ack` in 1: clears `alarm`.
- `hh`, `mm`, `ss` out 8 each: current time, BCD.
- `pm` out 1: in 12-hour mode, the PM flag; in 24-hour mode, 1 when hh ≥ 0x12.
- `sec_tick` out 1: one-cycle pulse on each second advance.
- `load_err` out 1: one-cycle pulse when a load is rejected.
- `alarm` out 1: sticky alarm flag.

## Operation

- Reset values:
  - hh = 0x12 when `MODE24`=0, 0x00 when `MODE24`=1.
  - mm = ss = 0x00.
  - pm = 0.
  - `sec_tick` = `load_err` = `alarm` = 0.
  - Prescaler = 0.
  - Alarm registers = 0x12:00 AM (12-hour mode) or 0x00:00 (24-hour mode).
- Priority: reset > load > advance.
- Prescaler counts cycles with `ena` high. Advance occurs when prescaler = TICK_DIV-1 and `ena`=1; the prescaler then returns to 0. `ena`=0 holds all state.
- Second/minute digits:
  - Each digit is 0..9.
  - ss: 0x59 → 0x00 with carry into mm.
  - mm: 0x59 → 0x00 with carry into hh.
- Hour rollover, 12-hour mode:
  - 0x11 → 0x12 toggles `pm`.
  - 0x12 → 0x01.
  - 0x09 → 0x10.
- Hour rollover, 24-hour mode:
  - 0x23 → 0x00.
  - 0x09 → 0x10; 0x19 → 0x20.
- Load validation. A load is accepted only if every nibble is ≤ 9, mm ≤ 0x59, ss ≤ 0x59, and hh is in range (0x01..0x12 in 12-hour mode, 0x00..0x23 in 24-hour mode).
  - Accepted: time replaced, prescaler cleared to 0, no `sec_tick` that cycle.
  - Rejected: state unchanged (the pending advance still occurs), `load_err` pulses.
- Alarm writes are always accepted; there is no range check.
- Alarm match: on an advance whose new value is alarm_hh:alarm_mm:00 (and pm = alarm_pm in 12-hour mode) with `alarm_en`=1, `alarm` sets.
  - Loads never trigger a match.
  - `alarm_ack` clears `alarm`; a set in the same cycle wins.
  - `alarm_en`=0 does not clear an already-set `alarm`.

## Timing

- All outputs are registered. Time updates at the edge where the advance condition holds; `sec_tick` is high during the following cycle together with the new time.
- Load latency: 1 cycle (new time visible after the edge sampling `load`=1).
- `alarm` rises in the same cycle as the matching `sec_tick`.
- Reset applied mid-count discards prescaler progress and pending alarm state.
- Full rollover carries complete in one edge (e.g. 12:59:59 PM → 01:00:00 PM in one cycle).

## Structure

- Shared package `rtc_pkg`:
  - BCD limit constants (SEC_MAX=8'h59, HR12_MAX=8'h12, HR24_MAX=8'h23).
  - Reset-hour constants.
  - A `bcd_valid(byte, max)` function.
- Sub-module `bcd2_counter`:
  - Two-digit BCD counter with `inc`, `load`, a runtime `max` and `wrap_val`, and `carry` out.
  - Instantiated three times; the hour instance uses `wrap_val` 0x01 (12-hour) or 0x00 (24-hour).
- Top level holds the prescaler, load validation, pm logic and alarm registers.

## Test plan

- `MODE24`=0, `TICK_DIV`=1: reset, then `ena`=1 for 3600 cycles → 01:00:00, pm=0; 3600 more cycles → 02:00:00.
- 12-hour mode: load 11:59:59 AM, one advance → 12:00:00, pm=1; load 12:59:59 PM, one advance → 01:00:00, pm=1.
- `MODE24`=1: load 0x23:59:59, one advance → 00:00:00, pm=0; load 0x19:59:59 → 0x20:00:00, pm=1.
- `TICK_DIV`=4 with `ena` toggling every cycle → advance every 8 cycles; load at prescaler=2 → prescaler restarts, next advance 4 enabled cycles later.
- Invalid loads (hh=0x13 in 12-hour mode, mm=0x60, ss=0x0A) → `load_err` pulse, time unchanged, concurrent advance still applied.
- Alarm 0x07:30 AM enabled; load 07:29:59 AM, advance → `alarm`=1 with `sec_tick`; ack in the same cycle as a new match → `alarm` stays 1; ack alone → 0.
